// File: rtl/pim_weight_loader.sv
// Weight-programming front end: assembles one crossbar column of weights into
// high/low byte-plane buffers, then holds a program pulse at the column address.
module pim_weight_loader #(
  parameter int INPUT_SIZE = 100,
  parameter int DEPTH      = 100,
  parameter int DATA_WIDTH = 16,
  parameter int WR_CYCLES  = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int PW = DATA_WIDTH / 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [AW-1:0]            start_addr_i,
  input  logic [AW-1:0]            end_addr_i,
  input  logic                     w_valid_i,
  input  logic [DATA_WIDTH-1:0]    w_data_i,
  output logic                     w_ready_o,
  output logic                     xb_wr_en_o,
  output logic [AW-1:0]            xb_addr_o,
  output logic [INPUT_SIZE*PW-1:0] xb_data_H_o,
  output logic [INPUT_SIZE*PW-1:0] xb_data_L_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int RW = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [RW-1:0] ROW_LAST   = RW'(INPUT_SIZE - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(WR_CYCLES - 1);
  localparam logic [AW-1:0] COL_LAST   = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, PROG, DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   col_q, col_d;
  logic [AW-1:0]   end_q, end_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   pulse_q, pulse_d;
  logic            wr_en_q, wr_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ready;
  logic            xfer;
  logic [PW-1:0]   bufH_q [INPUT_SIZE];
  logic [PW-1:0]   bufL_q [INPUT_SIZE];

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    end_d   = end_q;
    row_d   = row_q;
    pulse_d = pulse_q;
    ready   = 1'b0;
    xfer    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          col_d   = start_addr_i;
          end_d   = end_addr_i;
          row_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        ready = 1'b1;
        if (w_valid_i) begin
          xfer = 1'b1;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            pulse_d = '0;
            state_d = PROG;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      PROG: begin
        if (pulse_q == PULSE_LAST) begin
          pulse_d = '0;
          if (col_q == end_q) begin
            state_d = DONE;
          end else begin
            // Column addresses wrap modulo DEPTH, not modulo 2**AW.
            col_d   = (col_q == COL_LAST) ? '0 : col_q + AW'(1);
            state_d = FILL;
          end
        end else begin
          pulse_d = pulse_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    wr_en_d = (state_d == PROG);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      col_q   <= '0;
      end_q   <= '0;
      row_q   <= '0;
      pulse_q <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      end_q   <= end_d;
      row_q   <= row_d;
      pulse_q <= pulse_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int k = 0; k < INPUT_SIZE; k++) begin
        bufH_q[k] <= '0;
        bufL_q[k] <= '0;
      end
    end else if (xfer) begin
      bufH_q[row_q] <= w_data_i[DATA_WIDTH-1:PW];
      bufL_q[row_q] <= w_data_i[PW-1:0];
    end
  end

  for (genvar g = 0; g < INPUT_SIZE; g++) begin : g_planes
    assign xb_data_H_o[g*PW +: PW] = bufH_q[g];
    assign xb_data_L_o[g*PW +: PW] = bufL_q[g];
  end

  assign w_ready_o  = ready;
  assign xb_wr_en_o = wr_en_q;
  assign xb_addr_o  = col_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: doc/pim_weight_loader.md
# pim_weight_loader

Weight-programming front end for the PIM crossbar GEMM datapath. It accepts a stream of 16-bit weights and assembles them one crossbar column at a time. Each weight is split into high and low byte planes, and each finished column is written into the crossbar arrays at a column address, holding the program pulse for a fixed number of cycles. It is the write-side counterpart of the column-addressed read path used by the PIM compute units, and must complete before any GEMM run.

## Interface
Parameters:
- INPUT_SIZE, 100: weights per column (crossbar rows = input vector length).
- DEPTH, 100: crossbar columns; address width AW = clogb2(DEPTH).
- DATA_WIDTH, 16: weight width; each plane is DATA_WIDTH/2 bits.
- WR_CYCLES, 4: program-pulse length in cycles (≥1).

Ports:
- clk  in  1  sole clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request to begin loading; sampled only in IDLE.
- start_addr  in  AW  first column to program; sampled with start.
- end_addr  in  AW  last column to program; sampled with start.
- w_valid  in  1  weight beat valid.
- w_data  in  DATA_WIDTH  weight; beat k of a column is row k.
- w_ready  out  1  loader accepts a beat; transfer = w_valid & w_ready.
- xb_wr_en  out  1  crossbar column write strobe.
- xb_addr  out  AW  column being programmed.
- xb_data_H  out  INPUT_SIZE*DATA_WIDTH/2  high planes; row k at [k*8+7:k*8] = w_data[15:8].
- xb_data_L  out  INPUT_SIZE*DATA_WIDTH/2  low planes; row k at [k*8+7:k*8] = w_data[7:0].
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last column is programmed.

## Operation
State machine with states IDLE, FILL, PROG and DONE:
- **IDLE**
  - On start, latch start_addr into the column register and end_addr into an end register.
  - Clear the row counter, then go to FILL.
- **FILL**
  - w_ready = 1.
  - Each transfer writes the row byte planes into buffer slot row_cnt, then increments row_cnt.
  - When the transfer is at row_cnt == INPUT_SIZE-1, clear row_cnt and pulse counter, then go to PROG.
  - While w_valid = 0, hold; there is no timeout.
- **PROG**
  - w_ready = 0, xb_wr_en = 1, xb_addr = column register.
  - Hold for exactly WR_CYCLES cycles.
  - On the final cycle: if column == end register, go to DONE. Otherwise advance column = (column == DEPTH-1) ? 0 : column+1 and go to FILL.
- **DONE**
  - done = 1 for one cycle, then go to IDLE.

Rules and boundary conditions:
- The buffer is a register array. xb_data_H and xb_data_L drive directly from it and are stable for the whole pulse. Outside PROG their value is don't-care-but-defined: the last contents.
- start_addr > end_addr is wrap mode: columns are programmed modulo DEPTH until end_addr, inclusive.
- start_addr == end_addr programs exactly one column.
- Address values ≥ DEPTH are not checked; behaviour is unspecified.
- start asserted while busy is ignored, with no latching and no effect.
- w_valid outside FILL is ignored; no beat is consumed.
- Reset (rst = 0) at any cycle, including mid-FILL or mid-PROG:
  - Next state is IDLE, and the partial column is discarded.
  - xb_wr_en, w_ready, busy and done are all 0.
  - xb_addr = 0, the buffer is cleared to 0, and all counters are 0.

## Timing
- All outputs are registered, except w_ready, which decodes the current state.
- start sampled at edge E: busy = 1 and w_ready = 1 from cycle E+1.
- The last row beat accepted at edge N gives xb_wr_en = 1 in cycles N+1 … N+WR_CYCLES. xb_addr and data are valid in that same window.
- At the edge after the last PROG cycle, state is FILL (w_ready = 1) or DONE.
- Minimum cycles per column with w_valid held high: INPUT_SIZE + WR_CYCLES.
- Total for C columns: C·(INPUT_SIZE+WR_CYCLES) cycles from first ready to done, plus 1 cycle in DONE. busy falls with the done pulse's following edge.
- xb_wr_en is never high in consecutive columns without an intervening FILL of INPUT_SIZE beats.

## Test plan
Bench parameters: INPUT_SIZE=4, DEPTH=8, WR_CYCLES=3.
1. **Single column.** start_addr=2, end_addr=2, beats 0x1234,0x5678,0x9ABC,0xDEF0 back-to-back.
   - Required: xb_wr_en high 3 cycles with xb_addr=2, xb_data_H=0xDE9A5612, xb_data_L=0xF0BC7834.
   - Then done pulses once and busy drops.
2. **Throttled input.** Same as 1, but w_valid toggles 1-0-1-0.
   - Required: only 4 transfers are counted, and the write occurs one cycle after the 4th transfer with identical data.
3. **Wrap mode.** start_addr=6, end_addr=1.
   - Required: xb_addr sequence 6,7,0,1, four program pulses, done after the column-1 pulse, 4·7+1 cycles total.
4. **Start while busy.** Pulse start with start_addr=5 during the FILL of test 1.
   - Required: ignored; only column 2 is programmed.
5. **Reset mid-PROG.** Drive rst=0 in the 2nd pulse cycle.
   - Required: next cycle xb_wr_en=0, busy=0, xb_addr=0, buffer=0.
   - A fresh start then programs a correct column from row 0.
6. **Idle stream.** w_valid=1 while in IDLE and PROG.
   - Required: w_ready=0 and no beats consumed in those states.
